// File: rtl/comp_pkg.sv
// ============================================================================
// comp_pkg : shared types, cascade encodings and slice helper for comp_wide_seq
// Revision : 1.0
// ============================================================================
`default_nettype none

package comp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Cascade encodings, ordered {L,E,G}
   localparam logic [2:0] CASC_EQ = 3'b010;
   localparam logic [2:0] CASC_LT = 3'b100;
   localparam logic [2:0] CASC_GT = 3'b001;

   localparam int MAX_NBYTES = 16;
   localparam int MAXW       = 8 * MAX_NBYTES;

   // Byte slice idx of an operand zero-extended to the widest legal width
   function automatic logic [7:0] slice_sel(input logic [MAXW-1:0] operand,
                                            input logic [3:0]      idx);
      logic [MAXW-1:0] shifted;
      shifted = operand >> {idx, 3'b000};
      return shifted[7:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/comp8_cascade.sv
// ============================================================================
// comp8_cascade : combinational 8-bit 7485-style magnitude slice with cascade
// Revision : 1.0
// ============================================================================
`default_nettype none

module comp8_cascade (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic       lin_i,
   input  logic       ein_i,
   input  logic       gin_i,
   output logic       l_o,
   output logic       e_o,
   output logic       g_o
);

   always_comb begin
      l_o = lin_i;
      e_o = ein_i;
      g_o = gin_i;
      if (a_i > b_i) begin
         l_o = 1'b0;
         e_o = 1'b0;
         g_o = 1'b1;
      end else if (a_i < b_i) begin
         l_o = 1'b1;
         e_o = 1'b0;
         g_o = 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/comp_wide_seq.sv
// ============================================================================
// comp_wide_seq : wide unsigned comparator, one byte slice per clock, LSB first
// Revision : 1.0
// ============================================================================
`default_nettype none

module comp_wide_seq
   import comp_pkg::*;
#(
   parameter int NBYTES = 4,
   parameter int IDXW   = $clog2(NBYTES)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [8*NBYTES-1:0] a,
   input  logic [8*NBYTES-1:0] b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                lt,
   output logic                eq,
   output logic                gt
);

   localparam int W = 8 * NBYTES;
   localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NBYTES - 1);

   state_e          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [2:0]      casc_q, casc_d;
   logic [2:0]      res_q, res_d;

   logic [7:0]      w_a_byte;
   logic [7:0]      w_b_byte;
   logic            w_l, w_e, w_g;

   assign w_a_byte = slice_sel(MAXW'(a_q), 4'(idx_q));
   assign w_b_byte = slice_sel(MAXW'(b_q), 4'(idx_q));

   comp8_cascade u_slice (
      .a_i   (w_a_byte),
      .b_i   (w_b_byte),
      .lin_i (casc_q[2]),
      .ein_i (casc_q[1]),
      .gin_i (casc_q[0]),
      .l_o   (w_l),
      .e_o   (w_e),
      .g_o   (w_g)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         casc_q  <= CASC_EQ;
         res_q   <= 3'b000;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         casc_q  <= casc_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      casc_d  = casc_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               casc_d  = CASC_EQ;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            casc_d = {w_l, w_e, w_g};
            // idx holds at the last slice rather than wrapping
            if (idx_q == C_LAST_IDX) begin
               res_d   = {w_l, w_e, w_g};
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign lt        = res_q[2];
   assign eq        = res_q[1];
   assign gt        = res_q[0];

endmodule

`default_nettype wire

// File: tb/tb_comp_wide_seq.sv
// ============================================================================
// tb_comp_wide_seq : directed self-checking bench for comp_wide_seq (NBYTES=4)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_comp_wide_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a_s;
   logic [31:0] b_s;
   logic        out_valid;
   logic        out_ready;
   logic        lt, eq, gt;

   int compared;
   int mismatched;

   comp_wide_seq #(.NBYTES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a_s),
      .b         (b_s),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .lt        (lt),
      .eq        (eq),
      .gt        (gt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one operand pair and wait (bounded) for out_valid
   task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                         output logic [2:0] res, output bit ok);
      a_s      = av;
      b_s      = bv;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      ok  = 1'b0;
      res = 3'b000;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) begin
            ok  = 1'b1;
            res = {lt, eq, gt};
            break;
         end
         tick();
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      compared++;
      if ({in_ready, out_valid, lt, eq, gt} !== 5'b10000) begin
         mismatched++;
         $display("FAIL reset_state: got rdy/vld/l/e/g=%b want 10000",
                  {in_ready, out_valid, lt, eq, gt});
      end
   endtask

   task automatic test_single();
      a_s      = 32'h12345678;
      b_s      = 32'h12345679;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      compared++;
      if (in_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL single_in_ready_drop: got %b want 0", in_ready);
      end
      tick(); tick(); tick();
      compared++;
      if (out_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL single_early_valid: got %b want 0 at T+3", out_valid);
      end
      tick();
      compared++;
      if ({out_valid, lt, eq, gt} !== 4'b1100) begin
         mismatched++;
         $display("FAIL single_result: got vld/l/e/g=%b want 1100",
                  {out_valid, lt, eq, gt});
      end
      release_result();
      compared++;
      if ({in_ready, out_valid} !== 2'b10) begin
         mismatched++;
         $display("FAIL single_release: got rdy/vld=%b want 10", {in_ready, out_valid});
      end
   endtask

   task automatic test_msb_dominance();
      logic [2:0] res;
      bit         ok;
      run_op(32'h80000000, 32'h7FFFFFFF, res, ok);
      compared++;
      if (!ok || res !== 3'b001) begin
         mismatched++;
         $display("FAIL msb_gt: got ok=%0d l/e/g=%b want 001", ok, res);
      end
      release_result();
      run_op(32'h00FFFFFF, 32'h01000000, res, ok);
      compared++;
      if (!ok || res !== 3'b100) begin
         mismatched++;
         $display("FAIL msb_lt: got ok=%0d l/e/g=%b want 100", ok, res);
      end
      release_result();
   endtask

   task automatic test_equality();
      logic [2:0] res;
      bit         ok;
      run_op(32'hA5A5A5A5, 32'hA5A5A5A5, res, ok);
      compared++;
      if (!ok || res !== 3'b010) begin
         mismatched++;
         $display("FAIL eq_a5: got ok=%0d l/e/g=%b want 010", ok, res);
      end
      release_result();
      run_op(32'h00000000, 32'h00000000, res, ok);
      compared++;
      if (!ok || res !== 3'b010) begin
         mismatched++;
         $display("FAIL eq_zero: got ok=%0d l/e/g=%b want 010", ok, res);
      end
      release_result();
   endtask

   task automatic test_backpressure();
      logic [2:0] res;
      bit         ok;
      run_op(32'h00000001, 32'h00000000, res, ok);
      compared++;
      if (!ok || res !== 3'b001) begin
         mismatched++;
         $display("FAIL bp_result: got ok=%0d l/e/g=%b want 001", ok, res);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         compared++;
         if ({out_valid, in_ready, lt, eq, gt} !== 5'b10001) begin
            mismatched++;
            $display("FAIL bp_hold%0d: got vld/rdy/l/e/g=%b want 10001",
                     i, {out_valid, in_ready, lt, eq, gt});
         end
      end
      release_result();
      compared++;
      if ({out_valid, in_ready} !== 2'b01) begin
         mismatched++;
         $display("FAIL bp_release: got vld/rdy=%b want 01", {out_valid, in_ready});
      end
   endtask

   task automatic test_busy_ignore();
      bit ok;
      a_s      = 32'h00000005;
      b_s      = 32'h00000003;
      in_valid = 1'b1;
      tick();
      a_s = 32'h00000000;
      b_s = 32'hFFFFFFFF;
      ok  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      compared++;
      if (!ok || {lt, eq, gt} !== 3'b001) begin
         mismatched++;
         $display("FAIL busy_first_result: got ok=%0d l/e/g=%b want 001", ok, {lt, eq, gt});
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      compared++;
      if (in_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL busy_idle: got in_ready=%b want 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick(); tick();
      compared++;
      if ({out_valid, lt, eq, gt} !== 4'b1100) begin
         mismatched++;
         $display("FAIL busy_second_result: got vld/l/e/g=%b want 1100",
                  {out_valid, lt, eq, gt});
      end
      release_result();
   endtask

   task automatic test_reset_mid_run();
      a_s      = 32'hFFFFFFFF;
      b_s      = 32'h00000000;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      compared++;
      if ({out_valid, in_ready, lt, eq, gt} !== 5'b01000) begin
         mismatched++;
         $display("FAIL midrun_reset: got vld/rdy/l/e/g=%b want 01000",
                  {out_valid, in_ready, lt, eq, gt});
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         compared++;
         if ({out_valid, in_ready} !== 2'b01) begin
            mismatched++;
            $display("FAIL midrun_no_result%0d: got vld/rdy=%b want 01",
                     i, {out_valid, in_ready});
         end
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst        = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      a_s        = '0;
      b_s        = '0;
      test_reset();
      test_single();
      test_msb_dominance();
      test_equality();
      test_backpressure();
      test_busy_ignore();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
